// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the byte-serial RAM/IO port arbiter.
// Holds state/owner encodings, IO region decode and byte-lane helpers.
package mem_arbiter_pkg;

    localparam int         ADDR_W      = 32;
    localparam int         IO_BASE_BIT = 17;
    localparam logic [1:0] IO_REGION   = 2'b11;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    // Odd request lengths collapse to a full word.
    function automatic logic [2:0] len_bytes(input logic [2:0] len);
        case (len)
            LEN_B:   return LEN_B;
            LEN_H:   return LEN_H;
            default: return LEN_W;
        endcase
    endfunction

    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        return a[IO_BASE_BIT -: 2] == IO_REGION;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between ICache, LSB, the arbiter and the RAM/IO bus.
// slave = arbiter side, master = the clients and memory around it.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_done;
    logic [31:0]       ic_data;

    logic              ls_req;
    logic              ls_wr;
    logic [2:0]        ls_len;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_done;
    logic [31:0]       ls_rdata;

    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    modport slave (
        input  ic_req, ic_addr, ls_req, ls_wr, ls_len, ls_addr, ls_wdata,
               mem_din, io_buffer_full,
        output ic_done, ic_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

    modport master (
        output ic_req, ic_addr, ls_req, ls_wr, ls_len, ls_addr, ls_wdata,
               mem_din, io_buffer_full,
        input  ic_done, ic_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM/IO port between ICache fetches and LSB loads/stores,
// serialising each request into per-byte cycles and reassembling read words.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         clear,
    mem_arbiter_if.slave bus
);

    state_t            state_r;
    state_t            state_n_s;
    owner_t            owner_r;
    owner_t            last_grant_r;
    owner_t            winner_s;
    logic              grant_s;
    logic              stall_s;
    logic              rd_last_s;
    logic              wr_last_s;
    logic              done_s;
    logic              wr_r;
    logic [2:0]        cnt_r;
    logic [2:0]        cnt_inc_s;
    logic [2:0]        nbytes_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_next_s;
    logic [ADDR_W-1:0] mem_a_r;
    logic [7:0]        mem_dout_r;
    logic [31:0]       wdata_r;
    logic [31:0]       buf_r;
    logic [31:0]       buf_merged_s;
    logic [31:0]       ic_data_r;
    logic [31:0]       ls_rdata_r;

    // Byte-lane helpers: next byte address and the incoming byte merged into the word
    always_comb begin
        cnt_inc_s    = cnt_r + 3'd1;
        addr_next_s  = addr_r + {{(ADDR_W-3){1'b0}}, cnt_inc_s};
        buf_merged_s = put_byte(buf_r, cnt_r[1:0] - 2'd1, bus.mem_din);
        stall_s      = is_io(addr_r) && bus.io_buffer_full;
        rd_last_s    = (cnt_r == nbytes_r);
        wr_last_s    = (cnt_inc_s == nbytes_r);
    end

    // Round-robin pick; a flush vetoes any speculative read from being granted
    always_comb begin
        winner_s = OWN_IC;
        grant_s  = 1'b0;
        if (bus.ic_req && bus.ls_req) begin
            winner_s = (last_grant_r == OWN_IC) ? OWN_LS : OWN_IC;
        end else if (bus.ls_req) begin
            winner_s = OWN_LS;
        end else begin
            winner_s = OWN_IC;
        end
        if ((bus.ic_req || bus.ls_req) &&
            !(clear && ((winner_s == OWN_IC) || !bus.ls_wr))) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_n_s = (winner_s == OWN_LS && bus.ls_wr) ? ST_WRITE : ST_READ;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (clear) begin
                    state_n_s = ST_IDLE;
                end else if (rd_last_s) begin
                    state_n_s = ST_DONE;
                end else begin
                    state_n_s = ST_READ;
                end
            end
            ST_WRITE: begin
                if (!stall_s && wr_last_s) begin
                    state_n_s = ST_DONE;
                end else begin
                    state_n_s = ST_WRITE;
                end
            end
            ST_DONE: state_n_s = ST_IDLE;
            default: state_n_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else if (rdy) begin
            state_r <= state_n_s;
        end
    end

    // Request latch, byte counter, bus address/data and read assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r      <= OWN_IC;
            last_grant_r <= OWN_IC;
            wr_r         <= 1'b0;
            cnt_r        <= 3'd0;
            nbytes_r     <= 3'd0;
            addr_r       <= '0;
            mem_a_r      <= '0;
            mem_dout_r   <= 8'd0;
            wdata_r      <= 32'd0;
            buf_r        <= 32'd0;
            ic_data_r    <= 32'd0;
            ls_rdata_r   <= 32'd0;
        end else if (rdy) begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        owner_r      <= winner_s;
                        last_grant_r <= winner_s;
                        cnt_r        <= 3'd0;
                        buf_r        <= 32'd0;
                        if (winner_s == OWN_IC) begin
                            addr_r   <= bus.ic_addr;
                            mem_a_r  <= bus.ic_addr;
                            nbytes_r <= LEN_W;
                            wr_r     <= 1'b0;
                        end else begin
                            addr_r   <= bus.ls_addr;
                            mem_a_r  <= bus.ls_addr;
                            nbytes_r <= len_bytes(bus.ls_len);
                            wr_r     <= bus.ls_wr;
                            wdata_r  <= bus.ls_wdata;
                            if (bus.ls_wr) begin
                                mem_dout_r <= bus.ls_wdata[7:0];
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (!clear) begin
                        // cnt leads the returning byte by one cycle of RAM latency
                        if (cnt_r != 3'd0) begin
                            buf_r <= buf_merged_s;
                        end
                        if (rd_last_s) begin
                            if (owner_r == OWN_IC) begin
                                ic_data_r <= buf_merged_s;
                            end else begin
                                ls_rdata_r <= buf_merged_s;
                            end
                        end else begin
                            cnt_r <= cnt_inc_s;
                            if (!(cnt_inc_s == nbytes_r)) begin
                                mem_a_r <= addr_next_s;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (!stall_s && !wr_last_s) begin
                        cnt_r      <= cnt_inc_s;
                        mem_a_r    <= addr_next_s;
                        mem_dout_r <= get_byte(wdata_r, cnt_inc_s[1:0]);
                    end
                end
                ST_DONE: begin
                    cnt_r <= 3'd0;
                end
                default: begin
                    cnt_r <= 3'd0;
                end
            endcase
        end
    end

    // Write strobe and done pulses; a flush in the final read cycle swallows the pulse
    always_comb begin
        bus.mem_wr  = 1'b0;
        bus.ic_done = 1'b0;
        bus.ls_done = 1'b0;
        done_s      = (state_r == ST_DONE) && rdy;
        if ((state_r == ST_WRITE) && rdy && !stall_s) begin
            bus.mem_wr = 1'b1;
        end else begin
            bus.mem_wr = 1'b0;
        end
        bus.ic_done = done_s && (owner_r == OWN_IC) && !clear;
        bus.ls_done = done_s && (owner_r == OWN_LS) && (wr_r || !clear);
    end

    assign bus.mem_a    = mem_a_r;
    assign bus.mem_dout = mem_dout_r;
    assign bus.ic_data  = ic_data_r;
    assign bus.ls_rdata = ls_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a byte-level RAM model;
// expectations come from request length, address and a shadow memory image.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clear;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  ram     [4096];
    logic [7:0]  ref_ram [4096];
    logic        pl_we;
    logic [11:0] pl_a;
    logic [7:0]  pl_d;

    // RAM responder: one-cycle read latency, IO-region writes do not land in RAM
    always @(posedge clk) begin
        if (pl_we) begin
            ram[pl_a] <= pl_d;
        end else if (bus.mem_wr && (bus.mem_a[17:16] != 2'b11)) begin
            ram[bus.mem_a[11:0]] <= bus.mem_dout;
        end
        bus.mem_din <= ram[bus.mem_a[11:0]];
    end

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    int          ic_done_at;
    int          ls_done_at;
    int          ic_done_cnt;
    int          ls_done_cnt;
    logic [31:0] ic_got;
    logic [31:0] ls_got;
    logic [31:0] wa_q [$];
    logic [7:0]  wd_q [$];
    int          wc_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_log();
        ic_done_at  = -1;
        ls_done_at  = -1;
        ic_done_cnt = 0;
        ls_done_cnt = 0;
        ic_got      = 32'd0;
        ls_got      = 32'd0;
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    // One bus cycle: sample settled outputs, requesters drop req on their done
    task automatic cyc();
        #1;
        if (bus.ic_done) begin
            ic_done_cnt++;
            ic_done_at = cyc_n;
            ic_got     = bus.ic_data;
            bus.ic_req = 1'b0;
        end
        if (bus.ls_done) begin
            ls_done_cnt++;
            ls_done_at = cyc_n;
            ls_got     = bus.ls_rdata;
            bus.ls_req = 1'b0;
        end
        if (bus.mem_wr) begin
            wa_q.push_back(bus.mem_a);
            wd_q.push_back(bus.mem_dout);
            wc_q.push_back(cyc_n);
        end
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pl_we = 1'b1;
        pl_a  = a;
        pl_d  = d;
        ref_ram[a] = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    function automatic int nbytes_of(input logic [2:0] len);
        if (len == 3'd1) return 1;
        if (len == 3'd2) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input int n);
        logic [31:0] w;
        logic [31:0] ak;
        w = 32'd0;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            w[8*k +: 8] = ref_ram[ak[11:0]];
        end
        return w;
    endfunction

    task automatic model_store(input logic [31:0] a, input int n, input logic [31:0] d);
        logic [31:0] ak;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            ref_ram[ak[11:0]] = d[8*k +: 8];
        end
    endtask

    task automatic ls_set(input logic wr, input logic [2:0] len, input logic [31:0] a,
                          input logic [31:0] d);
        bus.ls_req   = 1'b1;
        bus.ls_wr    = wr;
        bus.ls_len   = len;
        bus.ls_addr  = a;
        bus.ls_wdata = d;
    endtask

    int          g;
    int          n;
    logic        is_ic;
    logic        wr;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;

    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        pl_we = 1'b0; pl_a = 12'd0; pl_d = 8'd0;
        bus.ic_req = 1'b0; bus.ic_addr = 32'd0;
        bus.ls_req = 1'b0; bus.ls_wr = 1'b0; bus.ls_len = 3'd0;
        bus.ls_addr = 32'd0; bus.ls_wdata = 32'd0; bus.io_buffer_full = 1'b0;
        clr_log();
        @(negedge clk);
        for (int i = 0; i < 4096; i++) begin
            pl_we = 1'b1;
            pl_a  = 12'(i);
            pl_d  = 8'($urandom);
            ref_ram[i] = pl_d;
            @(negedge clk);
        end
        pl_we = 1'b0;

        #1;
        chk("rst_mem_a", bus.mem_a, 32'd0);
        chk("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst_ic_done", 32'(bus.ic_done), 32'd0);
        chk("rst_ls_done", 32'(bus.ls_done), 32'd0);
        chk("rst_ic_data", bus.ic_data, 32'd0);
        chk("rst_ls_rdata", bus.ls_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        preload(12'h100, 8'h13); preload(12'h101, 8'h05);
        preload(12'h102, 8'hA0); preload(12'h103, 8'h00);
        preload(12'h005, 8'h80); preload(12'h202, 8'h5A);

        // Lone IC fetch
        clr_log(); g = cyc_n;
        bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_0100;
        run(10);
        chk("ic_lat", 32'(ic_done_at - g), 32'd6);
        chk("ic_data", ic_got, 32'h00A0_0513);
        chk("ic_pulse", 32'(ic_done_cnt), 32'd1);
        chk("ic_no_wr", 32'(wa_q.size()), 32'd0);

        // Both pending, last grant IC: store goes first
        clr_log(); g = cyc_n;
        exp = exp_read(32'h104, 4);
        bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_0104;
        ls_set(1'b1, 3'd2, 32'h0000_0200, 32'hDEAD_BEEF);
        model_store(32'h200, 2, 32'hDEAD_BEEF);
        run(14);
        chk("rrA_ls_lat", 32'(ls_done_at - g), 32'd3);
        chk("rrA_ic_lat", 32'(ic_done_at - g), 32'd10);
        chk("rrA_ic_data", ic_got, exp);
        chk("st_nwr", 32'(wa_q.size()), 32'd2);
        chk("st_a0", wa_q[0], 32'h200);
        chk("st_d0", 32'(wd_q[0]), 32'hEF);
        chk("st_a1", wa_q[1], 32'h201);
        chk("st_d1", 32'(wd_q[1]), 32'hBE);
        chk("st_c0", 32'(wc_q[0] - g), 32'd1);
        chk("st_c1", 32'(wc_q[1] - g), 32'd2);
        chk("st_ram202", 32'(ram[12'h202]), 32'h5A);

        // Lone byte load, zero-extended
        clr_log(); g = cyc_n;
        ls_set(1'b0, 3'd1, 32'h0000_0005, 32'd0);
        run(6);
        chk("ldb_lat", 32'(ls_done_at - g), 32'd3);
        chk("ldb_data", ls_got, 32'h0000_0080);

        // Both pending, last grant LS: fetch goes first
        clr_log(); g = cyc_n;
        bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_0100;
        ls_set(1'b0, 3'd2, 32'h0000_0200, 32'd0);
        run(14);
        chk("rrB_ic_lat", 32'(ic_done_at - g), 32'd6);
        chk("rrB_ls_lat", 32'(ls_done_at - g), 32'd11);
        chk("rrB_ls_data", ls_got, exp_read(32'h200, 2));

        // rdy low for two cycles mid-read
        clr_log(); g = cyc_n;
        ls_set(1'b0, 3'd1, 32'h0000_0005, 32'd0);
        cyc(); cyc();
        rdy = 1'b0; cyc(); cyc();
        rdy = 1'b1; run(6);
        chk("frz_lat", 32'(ls_done_at - g), 32'd5);
        chk("frz_data", ls_got, 32'h0000_0080);
        chk("frz_pulse", 32'(ls_done_cnt), 32'd1);

        // Flush two cycles into a fetch; pending load granted right after
        clr_log(); g = cyc_n;
        bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_0100;
        cyc();
        ls_set(1'b0, 3'd4, 32'h0000_0100, 32'd0);
        cyc();
        clear = 1'b1; bus.ic_req = 1'b0;
        cyc();
        clear = 1'b0;
        run(10);
        chk("abort_ic_pulse", 32'(ic_done_cnt), 32'd0);
        chk("abort_ls_lat", 32'(ls_done_at - g), 32'd9);
        chk("abort_ls_data", ls_got, 32'h00A0_0513);

        // Flush in the done cycle of a read swallows the pulse
        clr_log(); g = cyc_n;
        bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_0100;
        run(6);
        clear = 1'b1; bus.ic_req = 1'b0;
        cyc();
        clear = 1'b0;
        run(2);
        chk("donefl_pulse", 32'(ic_done_cnt), 32'd0);

        // Flush in idle blocks a fetch grant
        clr_log(); g = cyc_n;
        bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_0100;
        clear = 1'b1;
        cyc(); cyc();
        clear = 1'b0;
        run(10);
        chk("idlefl_lat", 32'(ic_done_at - g), 32'd8);
        chk("idlefl_data", ic_got, 32'h00A0_0513);

        // IO store with three stalled cycles and a flush mid-stall
        clr_log(); g = cyc_n;
        ls_set(1'b1, 3'd1, 32'h0003_0000, 32'h1234_56A5);
        cyc();
        bus.io_buffer_full = 1'b1; cyc();
        clear = 1'b1; cyc();
        clear = 1'b0; cyc();
        bus.io_buffer_full = 1'b0;
        run(5);
        chk("io_nwr", 32'(wa_q.size()), 32'd1);
        chk("io_wc", 32'(wc_q[0] - g), 32'd4);
        chk("io_a", wa_q[0], 32'h0003_0000);
        chk("io_d", 32'(wd_q[0]), 32'hA5);
        chk("io_lat", 32'(ls_done_at - g), 32'd5);

        // Wrap-around address with an odd length (treated as a word)
        clr_log(); g = cyc_n;
        ls_set(1'b0, 3'd3, 32'hFFFF_FFFE, 32'd0);
        run(9);
        chk("wrap_lat", 32'(ls_done_at - g), 32'd6);
        chk("wrap_data", ls_got, exp_read(32'hFFFF_FFFE, 4));

        // Randomized lone transactions against the shadow memory
        for (int t = 0; t < 40; t++) begin
            clr_log(); g = cyc_n;
            is_ic = 1'($urandom_range(0, 1));
            addr  = 32'($urandom_range(0, 4095));
            if (is_ic) begin
                exp = exp_read(addr, 4);
                bus.ic_req = 1'b1; bus.ic_addr = addr;
                run(8);
                chk("rnd_ic_lat", 32'(ic_done_at - g), 32'd6);
                chk("rnd_ic_data", ic_got, exp);
            end else begin
                wr    = 1'($urandom_range(0, 1));
                len   = 3'($urandom_range(0, 7));
                wdata = $urandom;
                n     = nbytes_of(len);
                ls_set(wr, len, addr, wdata);
                if (wr) begin
                    model_store(addr, n, wdata);
                    run(n + 3);
                    chk("rnd_st_lat", 32'(ls_done_at - g), 32'(n + 1));
                    chk("rnd_st_nwr", 32'(wa_q.size()), 32'(n));
                end else begin
                    exp = exp_read(addr, n);
                    run(n + 4);
                    chk("rnd_ld_lat", 32'(ls_done_at - g), 32'(n + 2));
                    chk("rnd_ld_data", ls_got, exp);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sequences the single byte-wide RAM/IO port and shares it between the ICache (32-bit instruction fetch) and the load/store buffer (1/2/4-byte loads and stores).
Serialises each request into per-byte address/data cycles, reassembles little-endian read data and returns a one-cycle done pulse.
Honours pipeline flush (jp_wrong) for speculative reads and throttles IO writes on io_buffer_full.
Sits between ICache/LSB and the top-level ram/io bus.

Parameters:
IO_BASE_BIT, 17, address bits [17:16]==2'b11 select the IO region (0x30000+)
ADDR_W, 32, address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low freezes all state
clear  in  1  jp_wrong flush from ROB
ic_req  in  1  ICache fetch request, held until ic_done
ic_addr  in  32  fetch byte address
ic_done  out  1  one-cycle pulse, ic_data valid
ic_data  out  32  fetched word, little-endian
ls_req  in  1  LSB request, held until ls_done
ls_wr  in  1  1=store, 0=load
ls_len  in  3  bytes: 1, 2 or 4
ls_addr  in  32  byte address
ls_wdata  in  32  store data; byte k = ls_wdata[8k+7:8k]
ls_done  out  1  one-cycle pulse
ls_rdata  out  32  load data, zero-extended above ls_len bytes
mem_din  in  8  RAM/IO read byte
mem_dout  out  8  write byte
mem_a  out  32  byte address
mem_wr  out  1  1=write this cycle
io_buffer_full  in  1  IO write queue full

Behaviour:
- Reset: state IDLE, cnt=0, mem_a=0, mem_dout=0, mem_wr=0, ic_done=ls_done=0, ic_data=ls_rdata=0, last_grant=IC.
- rdy=0: no register changes; mem_wr forced 0.
- States: IDLE, READ, WRITE, DONE. 3-bit byte counter cnt; latched addr, len, owner.
- Arbitration in IDLE, one grant per cycle:
  - If only one requester is pending, it wins.
  - If both are pending, the one not equal to last_grant wins (round-robin).
  - The winner is latched with its addr/len (IC len=4), last_grant updated, cnt=0.
  - Next state is READ, or WRITE for ls_wr=1.
  - No grant in a cycle where clear=1 and the winner would be IC or an LS load.
- RAM timing: mem_a presented in cycle t returns its byte on mem_din in t+1.
- READ of N bytes, grant in cycle G:
  - Cycles G+1..G+N: mem_a=addr+cnt, cnt++.
  - Cycles G+2..G+N+1: capture mem_din into byte cnt-1 of the data register.
  - DONE at G+N+2: owner's done=1 for exactly that cycle, data stable.
  - IC 4-byte fetch therefore has a 6-cycle latency from grant to ic_done.
- WRITE of N bytes, cycles G+1..: mem_a=addr+cnt, mem_dout=wdata byte cnt, mem_wr=1, cnt++.
  - IO stall: if addr[17:16]==2'b11 and io_buffer_full, that cycle drives mem_wr=0 and holds cnt.
  - After byte N-1 is written, DONE: ls_done=1.
  - Unstalled: done at G+N+1.
- DONE lasts one cycle, then IDLE. No grant in DONE; requesters drop req in the DONE cycle.
- Output hold: outside WRITE, mem_wr=0 and mem_a holds its last value.
- clear during READ (either owner): abort to IDLE next cycle, no done pulse, data register contents undefined.
- clear during WRITE or DONE-of-write: no effect; committed stores always complete.
- clear in DONE-of-read: the done pulse is suppressed.
- Address arithmetic: addr+cnt is 32-bit wrap-around.
- ls_len values other than 1/2/4: treated as 4.

Decomposition:
- defines.v: state encodings (IDLE/READ/WRITE/DONE), owner encodings (OWN_IC/OWN_LS), IO region mask, length constants.
- Single module. No sub-module is natural: the byte lane select/assemble logic is a few muxes.

Test Plan:
- IC fetch: ic_addr=0x100, RAM[0x100..0x103]=13,05,A0,00 -> ic_done 6 cycles after grant, ic_data=0x00A00513, mem_wr never 1.
- LS store: len=2, addr=0x200, wdata=0xDEADBEEF -> mem_wr=1 on two consecutive cycles with (0x200,EF),(0x201,BE); ls_done next cycle; RAM[0x202] unchanged.
- Simultaneous requests with last_grant=IC: LS granted first; IC granted in the IDLE cycle after LS DONE. Repeat with last_grant=LS -> IC first.
- clear two cycles into an IC fetch -> no ic_done pulse, IDLE next cycle; a pending ls_req is granted in the following cycle.
- IO write: addr=0x30000, len=1, io_buffer_full high for 3 cycles -> mem_wr=0 for those 3 cycles, then one write of the byte, ls_done next cycle. clear mid-stall is ignored.
- LS load: len=1, addr=0x5, RAM[5]=0x80 -> ls_rdata=0x00000080. Hold rdy=0 for 2 cycles mid-read -> same result, latency +2.
